// File: rtl/mem_io_responder.sv
// Generic single-clock FIFO used for the UART-tx byte stream.
// Latency: a pushed entry is visible on out_vld the cycle after the push (no bypass).
// Backpressure: in_rdy drops when full, except when a pop happens in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   in_vld,
    input  logic [W-1:0]           in_dat,
    output logic                   in_rdy,
    output logic                   out_vld,
    output logic [W-1:0]           out_dat,
    input  logic                   out_rdy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    // Status side kept apart from the push side so in_rdy never depends on in_vld.
    always_comb begin
        out_vld  = (count_q != '0);
        out_dat  = out_vld ? mem_q[rd_ptr_q] : '0;
        pop      = out_vld & out_rdy;
        in_rdy   = (count_q != FULL_CNT) | pop;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end

    always_comb begin
        push     = in_vld & in_rdy;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    assign count = count_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_dat;
        end
    end
endmodule

// CPU bus responder: byte RAM plus IO page (UART tx/rx, halt, cycle counter snapshot).
// Latency: reads return one cycle after presentation; RAM writes commit at the same edge.
// Backpressure: io_buffer_full warns two entries early; pushes into a full tx FIFO are dropped.
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halted,
    output logic        tx_overflow
);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]            ram_mem [2**RAM_ADDR_W];
    logic [7:0]            ram_dout_q;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  ram_rd, ram_wr, io_rd, io_wr, is_io;
    logic [15:0]           io_off;

    logic        rd_ram_q, rd_ram_d;
    logic [7:0]  io_rdata_q, io_rdata_d;
    logic        halted_q, halted_d;
    logic        tx_overflow_q, tx_overflow_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_dat_q, rx_dat_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] snap_q, snap_d;

    logic          tx_push_vld, tx_push_rdy;
    logic [7:0]    tx_push_dat;
    logic [CW-1:0] tx_count;

    logic unused_bus_a;
    assign unused_bus_a = ^bus_a[31:18];

    always_comb begin
        is_io    = (bus_a[17:16] == 2'b11);
        io_off   = bus_a[15:0];
        ram_addr = bus_a[RAM_ADDR_W-1:0];
        ram_rd   = rdy_in & ~bus_wr & ~is_io;
        ram_wr   = rdy_in &  bus_wr & ~is_io;
        io_rd    = rdy_in & ~bus_wr &  is_io;
        io_wr    = rdy_in &  bus_wr &  is_io;

        rd_ram_d    = rd_ram_q;
        io_rdata_d  = io_rdata_q;
        halted_d    = halted_q;
        rx_full_d   = rx_full_q;
        rx_dat_d    = rx_dat_q;
        snap_d      = snap_q;
        cycle_cnt_d = rdy_in ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        tx_push_vld = 1'b0;
        tx_push_dat = bus_wdata;

        if (ram_rd) begin
            rd_ram_d = 1'b1;
        end

        if (io_rd) begin
            rd_ram_d   = 1'b0;
            io_rdata_d = 8'h00;
            case (io_off)
                16'h0000: begin
                    io_rdata_d = rx_full_q ? rx_dat_q : 8'h00;
                    rx_full_d  = 1'b0;
                end
                // Byte 0 comes straight from the counter since the snapshot is taken now.
                16'h0004: begin
                    snap_d     = cycle_cnt_q;
                    io_rdata_d = cycle_cnt_q[7:0];
                end
                16'h0005: io_rdata_d = snap_q[15:8];
                16'h0006: io_rdata_d = snap_q[23:16];
                16'h0007: io_rdata_d = snap_q[31:24];
                default:  io_rdata_d = 8'h00;
            endcase
        end

        if (io_wr) begin
            if (io_off == 16'h0000) begin
                tx_push_vld = (bus_wdata != 8'h00);
            end else if (io_off == 16'h0004 && !halted_q) begin
                halted_d    = 1'b1;
                tx_push_vld = 1'b1;
                tx_push_dat = 8'h00;
            end
        end

        // rx_ready is registered emptiness, so a load can only follow an empty register.
        if (rx_valid && !rx_full_q) begin
            rx_full_d = 1'b1;
            rx_dat_d  = rx_data;
        end
    end

    assign tx_overflow_d  = tx_overflow_q | (tx_push_vld & ~tx_push_rdy);
    assign io_buffer_full = (tx_count >= CW'(TX_DEPTH - 2));
    assign bus_rdata      = rd_ram_q ? ram_dout_q : io_rdata_q;
    assign rx_ready       = ~rx_full_q;
    assign halted         = halted_q;
    assign tx_overflow    = tx_overflow_q;

    fifo #(
        .W     (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .in_vld  (tx_push_vld),
        .in_dat  (tx_push_dat),
        .in_rdy  (tx_push_rdy),
        .out_vld (tx_valid),
        .out_dat (tx_data),
        .out_rdy (tx_ready),
        .count   (tx_count)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ram_q      <= 1'b0;
            io_rdata_q    <= 8'h00;
            halted_q      <= 1'b0;
            tx_overflow_q <= 1'b0;
            rx_full_q     <= 1'b0;
            rx_dat_q      <= 8'h00;
            cycle_cnt_q   <= 32'd0;
            snap_q        <= 32'd0;
        end else begin
            rd_ram_q      <= rd_ram_d;
            io_rdata_q    <= io_rdata_d;
            halted_q      <= halted_d;
            tx_overflow_q <= tx_overflow_d;
            rx_full_q     <= rx_full_d;
            rx_dat_q      <= rx_dat_d;
            cycle_cnt_q   <= cycle_cnt_d;
            snap_q        <= snap_d;
        end
    end

    // RAM contents survive reset; the output mux is what returns 0x00 after reset.
    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram_mem[ram_addr] <= bus_wdata;
        end
        if (ram_rd) begin
            ram_dout_q <= ram_mem[ram_addr];
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus randomized traffic
// compared every cycle against a queue/associative-array model of the bus behaviour.
module tb_mem_io_responder;
    localparam int RAM_ADDR_W = 17;
    localparam int TX_DEPTH   = 8;

    logic        clk_in    = 1'b0;
    logic        rst_in    = 1'b1;
    logic        rdy_in    = 1'b0;
    logic [31:0] bus_a     = 32'h0;
    logic        bus_wr    = 1'b0;
    logic [7:0]  bus_wdata = 8'h00;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready  = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_valid  = 1'b0;
    logic        rx_ready;
    logic        halted;
    logic        tx_overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 0;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(
        .RAM_ADDR_W (RAM_ADDR_W),
        .TX_DEPTH   (TX_DEPTH)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .bus_a          (bus_a),
        .bus_wr         (bus_wr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .halted         (halted),
        .tx_overflow    (tx_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [7:0]  txq[$];
    logic [7:0]  ram_m [int];
    bit          rx_has   = 0;
    logic [7:0]  rx_val   = 8'h00;
    bit          halted_m = 0;
    bit          ovf_m    = 0;
    logic [31:0] cnt_m    = 32'h0;
    logic [31:0] snap_m   = 32'h0;
    logic [7:0]  rd_exp   = 8'h00;
    bit          rd_known = 1;

    task automatic model_reset();
        txq.delete();
        rx_has   = 0;
        rx_val   = 8'h00;
        halted_m = 0;
        ovf_m    = 0;
        cnt_m    = 32'h0;
        snap_m   = 32'h0;
        rd_exp   = 8'h00;
        rd_known = 1;
    endtask

    task automatic model_step();
        bit          pre_rx;
        bit          io;
        logic [15:0] off;
        int          key;
        bit          push;
        logic [7:0]  pval;
        pre_rx = rx_has;
        io     = (bus_a[17:16] == 2'b11);
        off    = bus_a[15:0];
        key    = int'(bus_a[16:0]);
        push   = 0;
        pval   = bus_wdata;
        if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
        if (rdy_in) begin
            if (!bus_wr && io) begin
                rd_known = 1;
                case (off)
                    16'h0000: begin rd_exp = pre_rx ? rx_val : 8'h00; rx_has = 0; end
                    16'h0004: begin snap_m = cnt_m; rd_exp = snap_m[7:0]; end
                    16'h0005: rd_exp = snap_m[15:8];
                    16'h0006: rd_exp = snap_m[23:16];
                    16'h0007: rd_exp = snap_m[31:24];
                    default:  rd_exp = 8'h00;
                endcase
            end else if (!bus_wr) begin
                rd_known = ram_m.exists(key);
                if (rd_known) rd_exp = ram_m[key];
            end else if (io) begin
                if (off == 16'h0000 && bus_wdata != 8'h00) push = 1;
                if (off == 16'h0004 && !halted_m) begin
                    halted_m = 1;
                    push     = 1;
                    pval     = 8'h00;
                end
            end else begin
                ram_m[key] = bus_wdata;
            end
            if (push) begin
                if (txq.size() < TX_DEPTH) txq.push_back(pval);
                else ovf_m = 1;
            end
            cnt_m = cnt_m + 32'd1;
        end
        if (rx_valid && !pre_rx) begin
            rx_has = 1;
            rx_val = rx_data;
        end
    endtask

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) model_reset();
        else model_step();
    end

    always @(negedge clk_in) begin
        if (started) begin
            chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
            if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
            chk("io_buffer_full", 32'(io_buffer_full), 32'(txq.size() >= TX_DEPTH - 2));
            chk("rx_ready", 32'(rx_ready), 32'(!rx_has));
            chk("halted", 32'(halted), 32'(halted_m));
            chk("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
            if (rd_known) chk("bus_rdata", 32'(bus_rdata), 32'(rd_exp));
        end
    end

    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] wd);
        bus_a     = a;
        bus_wr    = wr;
        bus_wdata = wd;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0002_0000, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        wr;
        logic [7:0]  wd;
        int          sel;
        int          pops;

        rdy_in = 1'b1;
        #2 rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        started = 1;
        chk("rst_bus_rdata", 32'(bus_rdata), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
        rst_in = 1'b1;

        // Cycle counter snapshot: 100 ready cycles after reset.
        idle(100);
        step(32'h0003_0004, 1'b0, 8'h00);
        chk("snap_b0", 32'(bus_rdata), 32'h64);
        step(32'h0003_0005, 1'b0, 8'h00);
        chk("snap_b1", 32'(bus_rdata), 32'h00);
        step(32'h0003_0006, 1'b0, 8'h00);
        chk("snap_b2", 32'(bus_rdata), 32'h00);
        step(32'h0003_0007, 1'b0, 8'h00);
        chk("snap_b3", 32'(bus_rdata), 32'h00);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) step(32'h0003_0000, 1'b1, 8'h55);
        chk("frozen_no_push", 32'(tx_valid), 32'h0);
        rdy_in = 1'b1;
        step(32'h0003_0004, 1'b0, 8'h00);
        chk("snap_frozen", 32'(bus_rdata), 32'h68);

        // RAM write then read back; a write with rdy_in low must not land.
        step(32'h0000_0010, 1'b1, 8'hA5);
        step(32'h0000_0010, 1'b0, 8'h00);
        chk("ram_readback", 32'(bus_rdata), 32'hA5);
        rdy_in = 1'b0;
        step(32'h0000_0010, 1'b1, 8'hEE);
        rdy_in = 1'b1;
        step(32'h0000_0010, 1'b0, 8'h00);
        chk("ram_rdy_low_write", 32'(bus_rdata), 32'hA5);

        // FIFO fill to overflow, then drain.
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(32'h0003_0000, 1'b1, 8'h41);
            if (i == 5) chk("ibf_at5", 32'(io_buffer_full), 32'h0);
            if (i == 6) chk("ibf_at6", 32'(io_buffer_full), 32'h1);
            if (i == 8) chk("ovf_at8", 32'(tx_overflow), 32'h0);
            if (i == 9) chk("ovf_at9", 32'(tx_overflow), 32'h1);
        end
        tx_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid) pops++;
            idle(1);
        end
        chk("drain_pops", 32'(pops), 32'd8);
        chk("drain_empty", 32'(tx_valid), 32'h0);

        // rx holding register.
        rx_data  = 8'h37;
        rx_valid = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        chk("rx_full", 32'(rx_ready), 32'h0);
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_read", 32'(bus_rdata), 32'h37);
        chk("rx_cleared", 32'(rx_ready), 32'h1);
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_read_empty", 32'(bus_rdata), 32'h00);

        // Zero writes ignored; halt pushes a 0x00 terminator.
        tx_ready = 1'b0;
        step(32'h0003_0000, 1'b1, 8'h00);
        chk("zero_no_push", 32'(tx_valid), 32'h0);
        step(32'h0003_0004, 1'b1, 8'h12);
        chk("halt_set", 32'(halted), 32'h1);
        chk("halt_tx_valid", 32'(tx_valid), 32'h1);
        chk("halt_tx_data", 32'(tx_data), 32'h00);
        step(32'h0003_0004, 1'b1, 8'h12);

        // Async reset mid-stream with five bytes queued.
        for (int i = 0; i < 4; i++) step(32'h0003_0000, 1'b1, 8'(8'h61 + i));
        chk("pre_rst_ibf", 32'(io_buffer_full), 32'h0);
        step(32'h0000_0010, 1'b0, 8'h00);
        chk("pre_rst_rdata", 32'(bus_rdata), 32'hA5);
        chk("pre_rst_valid", 32'(tx_valid), 32'h1);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'h0);
        chk("arst_tx_data", 32'(tx_data), 32'h00);
        chk("arst_rdata", 32'(bus_rdata), 32'h00);
        chk("arst_halted", 32'(halted), 32'h0);
        chk("arst_ovf", 32'(tx_overflow), 32'h0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        step(32'h0000_0010, 1'b0, 8'h00);
        chk("ram_kept", 32'(bus_rdata), 32'hA5);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                a[17:16] = 2'($urandom_range(0, 2));
                a[15:0]  = 16'($urandom_range(0, 15));
            end else if (sel < 9) begin
                a[17:16] = 2'b11;
                a[15:0]  = 16'($urandom_range(0, 8));
            end else begin
                a[17:16] = 2'b11;
            end
            wr = 1'($urandom_range(0, 1));
            if (a[17:16] == 2'b11 && a[15:0] == 16'h0004 && $urandom_range(0, 30) != 0) wr = 1'b0;
            wd       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            rdy_in   = ($urandom_range(0, 7) != 0);
            tx_ready = (c < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            if (c == 1500) begin
                #3 rst_in = 1'b0;
                @(posedge clk_in);
                #1;
                rst_in = 1'b1;
            end
            step(a, wr, wd);
        end
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
